// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the multicycle ALU: op codes (shared with the ALU decoder)
// and FSM state encodings.
package multicycle_alu_pkg;

    // 3-bit ALUControl codes as produced by the ALU decoder.
    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSll = 3'b100,
        AluSlt = 3'b101,
        AluXor = 3'b110,
        AluIll = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/multicycle_alu_serial_shifter.sv
// Serial left shifter: one bit per step, holds the accumulator and remaining count.
module multicycle_alu_serial_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;

    // Load operand and shift amount, then shift once per step until the count is exhausted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            acc_q <= din;
            cnt_q <= shamt;
        end else if (step && (cnt_q != '0)) begin
            acc_q <= acc_q << 1;
            cnt_q <= cnt_q - SHW'(1);
        end
    end

    assign busy = (cnt_q != '0);
    assign q    = acc_q;

endmodule

// File: rtl/multicycle_alu.sv
// Iterative ALU for the multicycle RV32I datapath. One op in flight; single-cycle logic and
// arithmetic ops, SLL shifted one bit per cycle. Valid/ready on both sides.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);

    state_e           state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] result_q;
    logic             out_valid_q, zero_q, illegal_q;

    logic             accept;
    logic             shift_step, shift_busy;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] comb_result;
    logic             comb_illegal;
    logic             exec_wait;

    // in_ready is gated by reset so nothing is accepted while reset is asserted.
    assign in_ready = reset && (state_q == StIdle);
    assign accept   = in_valid && in_ready;

    // SLL keeps EXEC busy until the shifter has consumed its count.
    assign exec_wait  = (op_q == AluSll) && shift_busy;
    assign shift_step = (state_q == StExec) && exec_wait;

    multicycle_alu_serial_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (shift_step),
        .din   (SrcA),
        .shamt (SrcB[SHW-1:0]),
        .busy  (shift_busy),
        .q     (shift_q)
    );

    // Single-cycle result from the latched operands.
    always_comb begin
        comb_result  = '0;
        comb_illegal = 1'b0;
        unique case (op_q)
            AluAdd:  comb_result = a_q + b_q;
            AluSub:  comb_result = a_q + ~b_q + WIDTH'(1);
            AluAnd:  comb_result = a_q & b_q;
            AluOr:   comb_result = a_q | b_q;
            AluXor:  comb_result = a_q ^ b_q;
            AluSlt:  comb_result = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            AluSll:  comb_result = shift_q;
            AluIll:  comb_illegal = 1'b1;
            default: comb_illegal = 1'b1;
        endcase
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            op_q        <= AluAdd;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= alu_op_e'(ALUControl);
                        a_q     <= SrcA;
                        b_q     <= SrcB;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (!exec_wait) begin
                        result_q    <= comb_result;
                        zero_q      <= (comb_result == '0);
                        illegal_q   <= comb_illegal;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu.
module tb_multicycle_alu;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALUControl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        Illegal;

    int total = 0;
    int bad   = 0;

    multicycle_alu #(
        .WIDTH (32),
        .SHW   (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op from IDLE, scramble inputs after accept, count edges until out_valid,
    // optionally hold backpressure, then complete the output handshake.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic expz,
                          input logic expil, input int explat, input int hold);
        int lat;
        for (int w = 0; w < 5 && !in_ready; w++) @(negedge clk);
        check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid   = 1'b1;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        @(posedge clk);
        @(negedge clk);
        in_valid   = 1'b0;
        ALUControl = ~op;
        SrcA       = ~a;
        SrcB       = ~b;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, ":lat"}, 32'(lat), 32'(explat));
        check({tag, ":res"}, ALUResult, exp);
        check({tag, ":zero"}, 32'(Zero), 32'(expz));
        check({tag, ":ill"}, 32'(Illegal), 32'(expil));
        check({tag, ":rdy_in_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ":hold_vld"}, 32'(out_valid), 32'd1);
            check({tag, ":hold_res"}, ALUResult, exp);
            check({tag, ":hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, ":idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        ALUControl = 3'b000;
        SrcA       = 32'h1;
        SrcB       = 32'h1;

        // Reset held with in_valid high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst:in_ready", 32'(in_ready), 32'd0);
            check("rst:out_valid", 32'(out_valid), 32'd0);
            check("rst:result", ALUResult, 32'd0);
            check("rst:zero", 32'(Zero), 32'd0);
            check("rst:illegal", 32'(Illegal), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("rst_rel:in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);

        run_op("add", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1, 0);
        run_op("sub", 3'b001, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 0);
        run_op("slt", 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1, 0);
        run_op("slt_f", 3'b101, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1, 0);
        run_op("xor", 3'b110, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b0, 1'b0, 1, 0);
        run_op("or", 3'b011, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1, 0);
        run_op("and", 3'b010, 32'hC, 32'hA, 32'h8, 1'b0, 1'b0, 1, 10);
        run_op("sll3", 3'b100, 32'h1, 32'hFFFF_FFE3, 32'h8, 1'b0, 1'b0, 4, 0);
        run_op("sll31", 3'b100, 32'h1, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32, 0);
        run_op("sll0", 3'b100, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1'b0, 1, 0);
        // out_ready already high before DONE
        out_ready = 1'b1;
        run_op("add_rdy", 3'b000, 32'h2, 32'h3, 32'h5, 1'b0, 1'b0, 1, 0);

        // Reset during a long shift: no out_valid pulse, back to IDLE.
        in_valid   = 1'b1;
        ALUControl = 3'b100;
        SrcA       = 32'h1;
        SrcB       = 32'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_mid:pre_vld", 32'(out_valid), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mid:vld", 32'(out_valid), 32'd0);
            check("rst_mid:rdy", 32'(in_ready), 32'd0);
        end
        reset = 1'b1;
        #1;
        check("rst_mid:idle", 32'(in_ready), 32'd1);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("rst_mid:no_pulse", 32'(out_valid), 32'd0);
        end
        check("rst_mid:result", ALUResult, 32'd0);

        run_op("ill", 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b1, 1'b1, 1, 0);
        run_op("add_after", 3'b000, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
